// File: rtl/wb_regfile_pkg.sv
// Shared core constants: the classic `define names plus typed localparams
// that the write-back stage and register file import.
`ifndef WB_REGFILE_DEFINES
`define WB_REGFILE_DEFINES
`define RstEnable    1'b1
`define WriteEnable  1'b1
`define ReadEnable   1'b1
`define RegBus       31:0
`define RegAddrBus   4:0
`define RegNum       32
`define ZeroWord     32'h0000_0000
`define NOPRegAddr   5'b00000
`endif

package wb_regfile_pkg;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = `RegNum;
  localparam logic [REG_W-1:0]      ZERO_WORD    = `ZeroWord;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = `NOPRegAddr;
endpackage

// File: rtl/wb_regfile_mem_wb.sv
// MEM/WB stage register carrying the {wd, wreg, wdata} result triple.
// Priority: rst > flush_i (bubble) > stall_i (hold) > load.
module mem_wb
  import wb_regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o
);

  always_ff @(posedge clk) begin
    if (rst == `RstEnable || flush_i) begin
      wd_o    <= '0;
      wreg_o  <= 1'b0;
      wdata_o <= '0;
    end else if (!stall_i) begin
      wd_o    <= wd_i;
      wreg_o  <= wreg_i;
      wdata_o <= wdata_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32 x 32 register file: commits the MEM/WB entry each
// cycle and serves two combinational read ports that bypass the pending write.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int          CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic                  re1_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic                  re2_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [REG_W-1:0]      rdata1_o,
  output logic [REG_W-1:0]      rdata2_o,
  output logic [REG_ADDR_W-1:0] wb_wd_o,
  output logic                  wb_wreg_o,
  output logic [REG_W-1:0]      wb_wdata_o,
  output logic [CNT_W-1:0]      wb_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_W-1:0] regs [0:REG_NUM-1];
  logic             commit;

  mem_wb #(.ADDR_W(REG_ADDR_W), .DATA_W(REG_W)) u_mem_wb (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .wd_i    (wd_i),
    .wreg_i  (wreg_i),
    .wdata_i (wdata_i),
    .wd_o    (wb_wd_o),
    .wreg_o  (wb_wreg_o),
    .wdata_o (wb_wdata_o)
  );

  // A stalled entry stays valid, so it is re-committed (and counted) every cycle.
  assign commit = (wb_wreg_o == `WriteEnable) && (wb_wd_o != NOP_REG_ADDR);

  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      wb_cnt_o <= '0;
      if (CLEAR_ON_RESET != 0) begin
        for (int i = 0; i < REG_NUM; i++) begin
          regs[i] <= ZERO_WORD;
        end
      end
    end else if (commit) begin
      regs[wb_wd_o] <= wb_wdata_o;
      wb_cnt_o      <= wb_cnt_o + CNT_ONE;
    end
  end

  function automatic logic [REG_W-1:0] read_port(
    input logic                  re,
    input logic [REG_ADDR_W-1:0] addr,
    input logic [REG_W-1:0]      array_val
  );
    if (rst == `RstEnable || re != `ReadEnable || addr == NOP_REG_ADDR) begin
      return ZERO_WORD;
    end else if (wb_wreg_o == `WriteEnable && wb_wd_o == addr) begin
      return wb_wdata_o;
    end else begin
      return array_val;
    end
  endfunction

  always_comb begin
    rdata1_o = read_port(re1_i, raddr1_i, regs[raddr1_i]);
    rdata2_o = read_port(re2_i, raddr2_i, regs[raddr2_i]);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a behavioural register-file model predicts
// every cycle's outputs, and a negedge monitor pops and compares them.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata1_o;
  logic [31:0] rdata2_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic [31:0] wb_cnt_o;

  wb_regfile #(.CLEAR_ON_RESET(1), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .re1_i      (re1_i),
    .raddr1_i   (raddr1_i),
    .re2_i      (re2_i),
    .raddr2_i   (raddr2_i),
    .rdata1_o   (rdata1_o),
    .rdata2_o   (rdata2_o),
    .wb_wd_o    (wb_wd_o),
    .wb_wreg_o  (wb_wreg_o),
    .wb_wdata_o (wb_wdata_o),
    .wb_cnt_o   (wb_cnt_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents, the one pending result
  // waiting to retire, and the number of retired writes.
  logic [31:0] m_regs [0:31];
  logic        m_pend_valid;
  logic [4:0]  m_pend_addr;
  logic [31:0] m_pend_data;
  logic [31:0] m_cnt;

  // Expected output vector: {rdata1, rdata2, wb_wd, wb_wreg, wb_wdata, cnt}
  localparam int W = 134;
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] model_read(input logic r, input logic re,
                                             input logic [4:0] addr);
    if (r || !re || addr == 5'd0) return 32'h0;
    if (m_pend_valid && m_pend_addr == addr) return m_pend_data;
    return m_regs[addr];
  endfunction

  // Advance the model across one rising edge using the inputs that were applied.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt        = 32'h0;
      m_pend_valid = 1'b0;
      m_pend_addr  = 5'd0;
      m_pend_data  = 32'h0;
    end else begin
      if (m_pend_valid && m_pend_addr != 5'd0) begin
        m_regs[m_pend_addr] = m_pend_data;
        m_cnt = m_cnt + 32'd1;
      end
      if (flush_i) begin
        m_pend_valid = 1'b0;
        m_pend_addr  = 5'd0;
        m_pend_data  = 32'h0;
      end else if (!stall_i) begin
        m_pend_valid = wreg_i;
        m_pend_addr  = wd_i;
        m_pend_data  = wdata_i;
      end
    end
  endtask

  // Driver: apply one cycle of inputs, record the expected response, cross the edge.
  task automatic drive(input logic r, input logic st, input logic fl,
                       input logic [4:0] wd, input logic we, input logic [31:0] wdat,
                       input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    rst = r; stall_i = st; flush_i = fl;
    wd_i = wd; wreg_i = we; wdata_i = wdat;
    re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
    exp_q.push_back({model_read(r, e1, a1), model_read(r, e2, a2),
                     m_pend_addr, m_pend_valid, m_pend_data, m_cnt});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle the driver has scheduled an expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("rdata1",   rdata1_o,          e[133:102]);
      chk("rdata2",   rdata2_o,          e[101:70]);
      chk("wb_wd",    {27'h0, wb_wd_o},  {27'h0, e[69:65]});
      chk("wb_wreg",  {31'h0, wb_wreg_o},{31'h0, e[64]});
      chk("wb_wdata", wb_wdata_o,        e[63:32]);
      chk("wb_cnt",   wb_cnt_o,          e[31:0]);
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0; m_pend_valid = 0; m_pend_addr = 0; m_pend_data = 0;
    rst = 1; stall_i = 0; flush_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0;
    re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0;
    @(posedge clk); #1;

    // Reset, then sweep every register on both ports
    drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 2);
    drive(1, 0, 0, 0, 0, 0, 1, 3, 1, 4);
    for (int a = 1; a < 32; a++) drive(0, 0, 0, 0, 0, 0, 1, 5'(a), 1, 5'(31 - a + 1));

    // Single write to r5: old value, then bypass, then array
    drive(0, 0, 0, 5, 1, 32'hDEADBEEF, 1, 5, 0, 5);
    drive(0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    drive(0, 0, 0, 0, 0, 0, 1, 5, 1, 5);

    // Write to r0 is discarded and not counted
    drive(0, 0, 0, 0, 1, 32'h12345678, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 5);

    // Back-to-back writes to r3 watched on port 2
    drive(0, 0, 0, 3, 1, 32'h11, 1, 3, 1, 3);
    drive(0, 0, 0, 3, 1, 32'h22, 1, 3, 1, 3);
    drive(0, 0, 0, 0, 0, 0, 1, 3, 1, 3);
    drive(0, 0, 0, 0, 0, 0, 1, 3, 1, 3);

    // Stall holding r7 = 0xAA while r8 = 0xBB waits at the input
    drive(0, 0, 0, 7, 1, 32'hAA, 1, 7, 1, 8);
    for (int k = 0; k < 3; k++) drive(0, 1, 0, 8, 1, 32'hBB, 1, 7, 1, 8);
    drive(0, 0, 0, 8, 1, 32'hBB, 1, 7, 1, 8);
    drive(0, 0, 0, 0, 0, 0, 1, 7, 1, 8);
    drive(0, 0, 0, 0, 0, 0, 1, 7, 1, 8);

    // Flush beats stall and drops the r9 input
    drive(0, 1, 1, 9, 1, 32'hCC, 1, 9, 1, 9);
    drive(0, 0, 0, 0, 0, 0, 1, 9, 1, 9);
    drive(0, 0, 0, 0, 0, 0, 1, 9, 1, 9);

    // Reset while r10 is pending suppresses its commit
    drive(0, 0, 0, 10, 1, 32'hDD, 1, 10, 1, 10);
    drive(1, 0, 0, 0, 0, 0, 1, 10, 1, 10);
    drive(0, 0, 0, 0, 0, 0, 1, 10, 1, 10);

    // Reset mid-stall clears the held entry
    drive(0, 0, 0, 11, 1, 32'hEE, 1, 11, 1, 11);
    drive(0, 1, 0, 12, 1, 32'hFF, 1, 11, 1, 12);
    drive(1, 1, 0, 12, 1, 32'hFF, 1, 11, 1, 12);
    drive(0, 0, 0, 0, 0, 0, 1, 11, 1, 12);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a1;
      a1 = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0),
            $urandom(),
            ($urandom_range(0, 7) != 0), a1,
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31)));
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
